// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings and the memory-stage state type.
package riscv_pkg;

   localparam int unsigned OPCODE_W = 7;
   localparam int unsigned FUNC3_W  = 3;
   localparam int unsigned REG_W    = 5;
   localparam int unsigned STRB_W   = 4;

   localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPCODE_W-1:0] OP_ALU    = 7'b0110011;
   localparam logic [OPCODE_W-1:0] OP_ALUI   = 7'b0010011;
   localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
   localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;

   localparam logic [FUNC3_W-1:0] F3_B  = 3'b000;
   localparam logic [FUNC3_W-1:0] F3_H  = 3'b001;
   localparam logic [FUNC3_W-1:0] F3_W  = 3'b010;
   localparam logic [FUNC3_W-1:0] F3_BU = 3'b100;
   localparam logic [FUNC3_W-1:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } mem_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: store strobes/replication, load extraction, misalignment.
module lsu_align
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [FUNC3_W-1:0] func3,
   input  logic [1:0]         off,
   input  logic [XLEN-1:0]    store_data,
   input  logic [FUNC3_W-1:0] ld_func3,
   input  logic [1:0]         ld_off,
   input  logic [XLEN-1:0]    rdata,
   output logic               misalign_c,
   output logic [STRB_W-1:0]  wstrb_c,
   output logic [XLEN-1:0]    wdata_c,
   output logic [XLEN-1:0]    ld_data_c
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Access size comes from func3[1:0]; 11 and above fall back to word
   always_comb begin
      misalign_c = 1'b0;
      wstrb_c    = 4'b1111;
      wdata_c    = store_data;
      case (func3[1:0])
         2'b00: begin
            wstrb_c = 4'(4'b0001 << off);
            wdata_c = {(XLEN/8){store_data[7:0]}};
         end
         2'b01: begin
            misalign_c = off[0];
            wstrb_c    = 4'(4'b0011 << off);
            wdata_c    = {(XLEN/16){store_data[15:0]}};
         end
         default: misalign_c = (off != 2'b00);
      endcase
   end

   always_comb begin
      ld_byte   = 8'(rdata >> {ld_off, 3'b000});
      ld_half   = ld_off[1] ? rdata[31:16] : rdata[15:0];
      ld_data_c = rdata;
      case (ld_func3)
         F3_B:    ld_data_c = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         F3_BU:   ld_data_c = {{(XLEN-8){1'b0}}, ld_byte};
         F3_H:    ld_data_c = {{(XLEN-16){ld_half[15]}}, ld_half};
         F3_HU:   ld_data_c = {{(XLEN-16){1'b0}}, ld_half};
         default: ld_data_c = rdata;
      endcase
   end

endmodule

// File: rtl/mem_wb.sv
// Memory/writeback stage: issues loads/stores on a valid/ready port and drives the regfile write port.
module mem_wb
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [FUNC3_W-1:0]  func3,
   input  logic [REG_W-1:0]    rd_number,
   input  logic [XLEN-1:0]     result,
   input  logic [XLEN-1:0]     rs2_val,
   output logic                stall,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic [XLEN-1:0]     dmem_addr,
   output logic [XLEN-1:0]     dmem_wdata,
   output logic [STRB_W-1:0]   dmem_wstrb,
   input  logic                dmem_ready,
   input  logic                dmem_rvalid,
   input  logic [XLEN-1:0]     dmem_rdata,
   output logic                wb_write,
   output logic [REG_W-1:0]    wb_dest_addr,
   output logic [XLEN-1:0]     wb_data,
   output logic                misalign_err
);

   mem_state_t           state;
   logic [FUNC3_W-1:0]   func3_q;
   logic [REG_W-1:0]     rd_q;
   logic [1:0]           off_q;
   logic                 misalign_c;
   logic [STRB_W-1:0]    wstrb_c;
   logic [XLEN-1:0]      wdata_c;
   logic [XLEN-1:0]      ld_data_c;
   logic                 accept_c;

   assign accept_c = in_valid && !stall;

   lsu_align #(.XLEN(XLEN)) u_align (
      .func3      (func3),
      .off        (result[1:0]),
      .store_data (rs2_val),
      .ld_func3   (func3_q),
      .ld_off     (off_q),
      .rdata      (dmem_rdata),
      .misalign_c (misalign_c),
      .wstrb_c    (wstrb_c),
      .wdata_c    (wdata_c),
      .ld_data_c  (ld_data_c)
   );

   // stall mirrors state != IDLE; it is updated alongside every state change
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         stall        <= 1'b0;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= '0;
         dmem_wstrb   <= '0;
         wb_write     <= 1'b0;
         wb_dest_addr <= '0;
         wb_data      <= '0;
         misalign_err <= 1'b0;
         func3_q      <= '0;
         rd_q         <= '0;
         off_q        <= '0;
      end else begin
         wb_write     <= 1'b0;
         misalign_err <= 1'b0;
         case (state)
            IDLE: begin
               if (accept_c) begin
                  case (opcode)
                     OP_LOAD, OP_STORE: begin
                        if (misalign_c) begin
                           misalign_err <= 1'b1;
                        end else begin
                           state      <= REQ;
                           stall      <= 1'b1;
                           dmem_req   <= 1'b1;
                           dmem_we    <= (opcode == OP_STORE);
                           dmem_addr  <= {result[XLEN-1:2], 2'b00};
                           dmem_wdata <= (opcode == OP_STORE) ? wdata_c : '0;
                           dmem_wstrb <= (opcode == OP_STORE) ? wstrb_c : '0;
                           func3_q    <= func3;
                           rd_q       <= rd_number;
                           off_q      <= result[1:0];
                        end
                     end
                     OP_ALU, OP_ALUI, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
                        wb_write     <= (rd_number != '0);
                        wb_dest_addr <= rd_number;
                        wb_data      <= result;
                     end
                     default: ;
                  endcase
               end
            end
            REQ: begin
               if (dmem_ready) begin
                  dmem_req <= 1'b0;
                  if (dmem_we) begin
                     state <= IDLE;
                     stall <= 1'b0;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (dmem_rvalid) begin
                  wb_write     <= (rd_q != '0);
                  wb_dest_addr <= rd_q;
                  wb_data      <= ld_data_c;
                  state        <= IDLE;
                  stall        <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               stall <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_wb.sv
// Directed self-checking bench for mem_wb.
module tb_mem_wb;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [6:0]  opcode;
   logic [2:0]  func3;
   logic [4:0]  rd_number;
   logic [31:0] result;
   logic [31:0] rs2_val;
   logic        stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ready;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        wb_write;
   logic [4:0]  wb_dest_addr;
   logic [31:0] wb_data;
   logic        misalign_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_wb #(.XLEN(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .opcode       (opcode),
      .func3        (func3),
      .rd_number    (rd_number),
      .result       (result),
      .rs2_val      (rs2_val),
      .stall        (stall),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_wstrb   (dmem_wstrb),
      .dmem_ready   (dmem_ready),
      .dmem_rvalid  (dmem_rvalid),
      .dmem_rdata   (dmem_rdata),
      .wb_write     (wb_write),
      .wb_dest_addr (wb_dest_addr),
      .wb_data      (wb_data),
      .misalign_err (misalign_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] res, input logic [31:0] rs2);
      in_valid  = 1'b1;
      opcode    = op;
      func3     = f3;
      rd_number = rd;
      result    = res;
      rs2_val   = rs2;
      tick();
      in_valid  = 1'b0;
   endtask

   task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] exp);
      issue(7'b0000011, f3, 5'd3, 32'h0000_1002, 32'h0);
      check({tag, "_req"},   32'(dmem_req), 32'd1);
      check({tag, "_addr"},  dmem_addr, 32'h0000_1000);
      check({tag, "_we"},    32'(dmem_we), 32'd0);
      check({tag, "_stall"}, 32'(stall), 32'd1);
      dmem_ready = 1'b1;
      tick();
      dmem_ready = 1'b0;
      check({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
      check({tag, "_wait_stall"}, 32'(stall), 32'd1);
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h0080_0000;
      tick();
      dmem_rvalid = 1'b0;
      check({tag, "_wb"},    32'(wb_write), 32'd1);
      check({tag, "_dest"},  32'(wb_dest_addr), 32'd3);
      check({tag, "_data"},  wb_data, exp);
      check({tag, "_idle"},  32'(stall), 32'd0);
      tick();
      check({tag, "_wb_pulse"}, 32'(wb_write), 32'd0);
   endtask

   initial begin
      reset       = 1'b0;
      in_valid    = 1'b0;
      opcode      = '0;
      func3       = '0;
      rd_number   = '0;
      result      = '0;
      rs2_val     = '0;
      dmem_ready  = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = '0;
      tick();
      tick();
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_req",   32'(dmem_req), 32'd0);
      check("rst_wb",    32'(wb_write), 32'd0);
      check("rst_data",  wb_data, 32'd0);
      check("rst_mis",   32'(misalign_err), 32'd0);
      reset = 1'b1;
      tick();

      // ADD rd=5
      issue(7'b0110011, 3'b000, 5'd5, 32'h0000_0042, 32'h0);
      check("add_wb",    32'(wb_write), 32'd1);
      check("add_dest",  32'(wb_dest_addr), 32'd5);
      check("add_data",  wb_data, 32'h0000_0042);
      check("add_stall", 32'(stall), 32'd0);
      tick();
      check("add_pulse", 32'(wb_write), 32'd0);

      load_case("lb",  3'b000, 32'hFFFF_FF80);
      load_case("lbu", 3'b100, 32'h0000_0080);

      // SH with ready delayed 3 cycles
      issue(7'b0100011, 3'b001, 5'd0, 32'h0000_2002, 32'h1234_ABCD);
      for (int i = 0; i < 3; i++) begin
         check("sh_req",   32'(dmem_req), 32'd1);
         check("sh_we",    32'(dmem_we), 32'd1);
         check("sh_addr",  dmem_addr, 32'h0000_2000);
         check("sh_strb",  32'(dmem_wstrb), 32'h0000_000C);
         check("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
         check("sh_stall", 32'(stall), 32'd1);
         check("sh_nowb",  32'(wb_write), 32'd0);
         if (i == 2) dmem_ready = 1'b1;
         tick();
      end
      dmem_ready = 1'b0;
      check("sh_done_req",   32'(dmem_req), 32'd0);
      check("sh_done_stall", 32'(stall), 32'd0);
      check("sh_done_nowb",  32'(wb_write), 32'd0);

      // SB at byte offset 1, ready on first request cycle
      issue(7'b0100011, 3'b000, 5'd0, 32'h0000_5001, 32'h0000_00A5);
      check("sb_strb",  32'(dmem_wstrb), 32'h0000_0002);
      check("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
      dmem_ready = 1'b1;
      tick();
      dmem_ready = 1'b0;
      check("sb_idle", 32'(stall), 32'd0);

      // Misaligned LW, then ADDI rd=0 back-to-back
      issue(7'b0000011, 3'b010, 5'd7, 32'h0000_3001, 32'h0);
      check("mis_err",   32'(misalign_err), 32'd1);
      check("mis_noreq", 32'(dmem_req), 32'd0);
      check("mis_stall", 32'(stall), 32'd0);
      check("mis_nowb",  32'(wb_write), 32'd0);
      issue(7'b0010011, 3'b000, 5'd0, 32'h0000_0099, 32'h0);
      check("mis_pulse", 32'(misalign_err), 32'd0);
      check("addi_x0",   32'(wb_write), 32'd0);

      // BRANCH writes nothing
      issue(7'b1100011, 3'b000, 5'd9, 32'h0000_0011, 32'h0);
      check("br_nowb", 32'(wb_write), 32'd0);

      // Reset while waiting on load data, then stale rvalid
      issue(7'b0000011, 3'b010, 5'd4, 32'h0000_4000, 32'h0);
      dmem_ready = 1'b1;
      tick();
      dmem_ready = 1'b0;
      check("rw_wait_stall", 32'(stall), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("rw_stall", 32'(stall), 32'd0);
      check("rw_req",   32'(dmem_req), 32'd0);
      check("rw_addr",  dmem_addr, 32'd0);
      check("rw_data",  wb_data, 32'd0);
      check("rw_dest",  32'(wb_dest_addr), 32'd0);
      tick();
      reset = 1'b1;
      tick();
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hDEAD_BEEF;
      tick();
      dmem_rvalid = 1'b0;
      check("stale_nowb",  32'(wb_write), 32'd0);
      check("stale_data",  wb_data, 32'd0);
      check("stale_stall", 32'(stall), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
